cpu_bus_arbiter: RTL and testbench

CPU_BUS_ARBITER -- requirements
Module: cpu_bus_arbiter

---
 rtl/cpu_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_cpu_bus_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: two requesters sharing one strobed
// CPU register bus, alternating on contention.
module cpu_bus_arbiter #(
  parameter int C_CPU_ADDR_WIDTH = 16,
  parameter int C_STROBE_CYCLES  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        m0_req,
  input  logic                        m0_we,
  input  logic [C_CPU_ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]                 m0_wdata,
  output logic                        m0_ack,
  output logic [31:0]                 m0_rdata,
  input  logic                        m1_req,
  input  logic                        m1_we,
  input  logic [C_CPU_ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]                 m1_wdata,
  output logic                        m1_ack,
  output logic [31:0]                 m1_rdata,
  output logic [C_CPU_ADDR_WIDTH-1:0] cpu_addr,
  output logic                        cpu_cs,
  output logic [31:0]                 cpu_wdata,
  output logic                        cpu_we,
  output logic                        cpu_rd,
  input  logic [31:0]                 cpu_rdata,
  output logic                        busy,
  output logic [1:0]                  grant
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } state_t;

  localparam logic [3:0] LAST =
    4'(C_STROBE_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  cnt_q;
  logic        sel_q;
  logic        we_q;
  logic        last_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic        win;
  logic        any_req;
  logic        strobe_end;

  assign any_req    = m0_req | m1_req;
  assign strobe_end = (cnt_q == LAST);
  assign m0_rdata   = rdata0_q;
  assign m1_rdata   = rdata1_q;

  // Winner: alternate on contention, else the lone requester.
  always_comb begin
    if (m0_req && m1_req) win = ~last_q;
    else                  win = m1_req;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and bus/handshake outputs decoded from state.
  always_comb begin
    state_d = state_q;
    cpu_cs  = 1'b1;
    cpu_we  = 1'b1;
    cpu_rd  = 1'b1;
    busy    = 1'b0;
    grant   = 2'b00;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) state_d = SETUP;
      end
      SETUP: begin
        cpu_cs  = 1'b0;
        busy    = 1'b1;
        grant   = sel_q ? 2'b10 : 2'b01;
        state_d = STROBE;
      end
      STROBE: begin
        cpu_cs = 1'b0;
        cpu_we = ~we_q;
        cpu_rd = we_q;
        busy   = 1'b1;
        grant  = sel_q ? 2'b10 : 2'b01;
        if (strobe_end) state_d = HOLD;
      end
      HOLD: begin
        cpu_cs  = 1'b0;
        busy    = 1'b1;
        grant   = sel_q ? 2'b10 : 2'b01;
        state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        grant   = sel_q ? 2'b10 : 2'b01;
        m0_ack  = ~sel_q;
        m1_ack  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's request, count strobe, capture read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 4'd0;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      last_q    <= 1'b1;
      cpu_addr  <= '0;
      cpu_wdata <= 32'd0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            cnt_q     <= 4'd0;
            sel_q     <= win;
            we_q      <= win ? m1_we : m0_we;
            cpu_addr  <= win ? m1_addr : m0_addr;
            cpu_wdata <= win ? m1_wdata : m0_wdata;
          end
        end
        STROBE: begin
          if (!strobe_end) begin
            cnt_q <= cnt_q + 4'd1;
          end else if (!we_q) begin
            if (sel_q) rdata1_q <= cpu_rdata;
            else       rdata0_q <= cpu_rdata;
          end
        end
        DONE: last_q <= sel_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb_cpu_bus_arbiter: directed and random traffic with a
// per-requester scoreboard checked at each ack.
module tb_cpu_bus_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_ack;
  logic [15:0] m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [15:0] m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [15:0] cpu_addr;
  logic        cpu_cs, cpu_we, cpu_rd, busy;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [1:0]  grant;

  logic        p0_req, p0_we, p0_ack;
  logic [15:0] p0_addr;
  logic [31:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_ack;
  logic [15:0] p1_addr;
  logic [31:0] p1_wdata, p1_rdata;
  logic [15:0] c1_addr;
  logic        c1_cs, c1_we, c1_rd, busy1;
  logic [31:0] c1_wdata, c1_rdata;
  logic [1:0]  grant1;

  logic        rd_fixed;
  int          n_chk = 0;
  int          n_fail = 0;
  int          issued = 0;
  int          acked = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] exp_rd0, exp_rd1;
  int          slo;
  logic [15:0] s_addr;
  logic [31:0] s_wd;
  logic        s_rd;

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_fn(
    input logic [15:0] a, input logic f);
    return f ? 32'h1234_5678 : {a ^ 16'hC3E1, ~a};
  endfunction

  always_comb cpu_rdata = rd_fn(cpu_addr, rd_fixed);
  always_comb c1_rdata  = rd_fn(c1_addr, 1'b0);

  cpu_bus_arbiter #(
    .C_CPU_ADDR_WIDTH(16),
    .C_STROBE_CYCLES (4)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_rdata(cpu_rdata),
    .busy(busy), .grant(grant)
  );

  cpu_bus_arbiter #(
    .C_CPU_ADDR_WIDTH(16),
    .C_STROBE_CYCLES (1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .m0_req(p0_req), .m0_we(p0_we), .m0_addr(p0_addr),
    .m0_wdata(p0_wdata), .m0_ack(p0_ack), .m0_rdata(p0_rdata),
    .m1_req(p1_req), .m1_we(p1_we), .m1_addr(p1_addr),
    .m1_wdata(p1_wdata), .m1_ack(p1_ack), .m1_rdata(p1_rdata),
    .cpu_addr(c1_addr), .cpu_cs(c1_cs), .cpu_wdata(c1_wdata),
    .cpu_we(c1_we), .cpu_rd(c1_rd), .cpu_rdata(c1_rdata),
    .busy(busy1), .grant(grant1)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, want);
    end
  endtask

  task automatic issue(input int who, input logic w,
                       input logic [15:0] a,
                       input logic [31:0] d);
    exp_t e;
    e.we = w; e.addr = a; e.wdata = d;
    issued++;
    if (who == 0) begin
      if (!w) exp_rd0 = rd_fn(a, rd_fixed);
      e.rdata = exp_rd0;
      q0.push_back(e);
      m0_we = w; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
    end else begin
      if (!w) exp_rd1 = rd_fn(a, rd_fixed);
      e.rdata = exp_rd1;
      q1.push_back(e);
      m1_we = w; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
    end
  endtask

  task automatic clr_model();
    issued -= q0.size() + q1.size();
    q0.delete();
    q1.delete();
    exp_rd0 = 32'd0;
    exp_rd1 = 32'd0;
  endtask

  task automatic on_ack(input int who, input logic [31:0] rd);
    exp_t e;
    int sz;
    sz = (who == 0) ? q0.size() : q1.size();
    chk("ack_pending", 64'(sz > 0), 64'd1);
    if (sz > 0) begin
      if (who == 0) e = q0.pop_front();
      else          e = q1.pop_front();
      acked++;
      chk("ack_grant", 64'(grant),
          (who == 0) ? 64'd1 : 64'd2);
      chk("ack_addr", 64'(s_addr), 64'(e.addr));
      chk("ack_dir_read", 64'(s_rd), 64'(!e.we));
      chk("ack_strobe_len", 64'(slo), 64'd4);
      chk("ack_rdata", 64'(rd), 64'(e.rdata));
      if (e.we) chk("ack_wdata", 64'(s_wd), 64'(e.wdata));
    end
    slo = 0;
  endtask

  // Bus protocol checks and scoreboard pops on every ack.
  always @(negedge clk) begin
    chk("we_rd_excl", 64'(cpu_we | cpu_rd), 64'd1);
    chk("strobe_no_cs",
        64'(cpu_cs & ~(cpu_we & cpu_rd)), 64'd0);
    chk("we_rd_excl_n1", 64'(c1_we | c1_rd), 64'd1);
    chk("strobe_no_cs_n1",
        64'(c1_cs & ~(c1_we & c1_rd)), 64'd0);
    chk("n1_m1_ack_idle", 64'(p1_ack), 64'd0);
    if (!busy) slo = 0;
    if (!cpu_we || !cpu_rd) begin
      slo++;
      s_addr = cpu_addr;
      s_wd   = cpu_wdata;
      s_rd   = !cpu_rd;
    end
    if (m0_ack) on_ack(0, m0_rdata);
    if (m1_ack) on_ack(1, m1_rdata);
  end

  task automatic run_txn(input int who, input logic w,
                         input logic [15:0] a,
                         input logic [31:0] d,
                         output int ak, output int wl,
                         output int rl);
    ak = 0; wl = 0; rl = 0;
    issue(who, w, a, d);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (!cpu_we) wl++;
      if (!cpu_rd) rl++;
      if (k == 1) begin
        chk("setup_grant", 64'(grant),
            (who == 0) ? 64'd1 : 64'd2);
        chk("setup_cs", 64'(cpu_cs), 64'd0);
      end
      if (who == 0 ? m0_ack : m1_ack) begin
        ak = k;
        break;
      end
    end
    if (who == 0) m0_req = 1'b0;
    else          m1_req = 1'b0;
  endtask

  initial begin
    int ak, wl, rl, na, rem0, rem1;
    int order[4];
    int ackc[4];
    bit re0, re1, cool0, cool1;
    rst = 1'b1; rd_fixed = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    exp_rd0 = 0; exp_rd1 = 0;
    slo = 0; s_addr = 0; s_wd = 0; s_rd = 0;
    repeat (3) @(negedge clk);

    chk("rst_cs", 64'(cpu_cs), 64'd1);
    chk("rst_we", 64'(cpu_we), 64'd1);
    chk("rst_rd", 64'(cpu_rd), 64'd1);
    chk("rst_addr", 64'(cpu_addr), 64'd0);
    chk("rst_wdata", 64'(cpu_wdata), 64'd0);
    chk("rst_acks", 64'({m0_ack, m1_ack}), 64'd0);
    chk("rst_rdata0", 64'(m0_rdata), 64'd0);
    chk("rst_rdata1", 64'(m1_rdata), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_n1_bus", 64'({c1_cs, c1_addr, c1_wdata}),
        64'h1_0000_0000_0000);
    chk("rst_n1_rdata1", 64'(p1_rdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(0, 1'b1, 16'h0010, 32'hA5A5_5A5A, ak, wl, rl);
    chk("wr_ack_cycle", 64'(ak), 64'd7);
    chk("wr_we_low", 64'(wl), 64'd4);
    chk("wr_rd_low", 64'(rl), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_addr_hold", 64'(cpu_addr), 64'h0010);
    chk("idle_wdata_hold", 64'(cpu_wdata), 64'hA5A5_5A5A);
    chk("idle_busy", 64'(busy), 64'd0);

    rd_fixed = 1'b1;
    run_txn(1, 1'b0, 16'h0020, 32'h0, ak, wl, rl);
    rd_fixed = 1'b0;
    chk("rd_ack_cycle", 64'(ak), 64'd7);
    chk("rd_rd_low", 64'(rl), 64'd4);
    chk("rd_we_low", 64'(wl), 64'd0);
    chk("rd_m1_rdata", 64'(m1_rdata), 64'h1234_5678);
    chk("rd_m0_kept", 64'(m0_rdata), 64'(exp_rd0));
    repeat (4) @(negedge clk);
    chk("rd_m1_hold", 64'(m1_rdata), 64'h1234_5678);

    rst = 1'b1;
    @(negedge clk);
    clr_model();
    issue(0, 1'b1, 16'h0100, 32'h1111_0000);
    issue(1, 1'b0, 16'h0200, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    na = 0; rem0 = 1; rem1 = 1; re0 = 0; re1 = 0;
    for (int i = 0; i < 4; i++) begin
      order[i] = -1;
      ackc[i]  = 0;
    end
    for (int k = 1; k <= 60 && na < 4; k++) begin
      @(negedge clk);
      if (re0) begin
        re0 = 0;
        issue(0, 1'b0, 16'h0101, 32'h0);
      end
      if (re1) begin
        re1 = 0;
        issue(1, 1'b1, 16'h0201, 32'h2222_0000);
      end
      if (m0_ack && na < 4) begin
        order[na] = 0; ackc[na] = k; na++;
        m0_req = 1'b0;
        if (rem0 > 0) begin rem0--; re0 = 1; end
      end
      if (m1_ack && na < 4) begin
        order[na] = 1; ackc[na] = k; na++;
        m1_req = 1'b0;
        if (rem1 > 0) begin rem1--; re1 = 1; end
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    for (int i = 0; i < 4; i++)
      chk("cont_order", 64'(order[i]), 64'(i % 2));
    chk("cont_first_ack", 64'(ackc[0]), 64'd7);
    for (int i = 1; i < 4; i++)
      chk("cont_period", 64'(ackc[i] - ackc[i-1]), 64'd8);

    @(negedge clk);
    issue(0, 1'b1, 16'h0040, 32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    chk("abort_in_strobe", 64'(cpu_we), 64'd0);
    rst = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("abort_cs", 64'(cpu_cs), 64'd1);
    chk("abort_we", 64'(cpu_we), 64'd1);
    chk("abort_rd", 64'(cpu_rd), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ack", 64'(m0_ack), 64'd0);
    clr_model();
    rst = 1'b0;
    ak = 0;
    repeat (12) begin
      @(negedge clk);
      if (m0_ack || m1_ack) ak++;
    end
    chk("abort_no_ack", 64'(ak), 64'd0);

    p0_we = 1'b0; p0_addr = 16'h0077; p0_req = 1'b1;
    ak = 0; wl = 0; rl = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!c1_rd) rl++;
      if (!c1_we) wl++;
      if (k == 1) chk("n1_grant", 64'({busy1, grant1}), 64'h5);
      if (p0_ack) begin ak = k; break; end
    end
    p0_req = 1'b0;
    chk("n1_ack_cycle", 64'(ak), 64'd4);
    chk("n1_rd_low", 64'(rl), 64'd1);
    chk("n1_we_low", 64'(wl), 64'd0);
    chk("n1_rdata", 64'(p0_rdata),
        64'(rd_fn(16'h0077, 1'b0)));

    cool0 = 0; cool1 = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (m0_ack) begin
        m0_req = 1'b0; cool0 = 1;
      end else if (cool0) begin
        cool0 = 0;
      end else if (!m0_req && $urandom_range(3) == 0) begin
        issue(0, 1'($urandom_range(1)), 16'($urandom),
              $urandom);
      end
      if (m1_ack) begin
        m1_req = 1'b0; cool1 = 1;
      end else if (cool1) begin
        cool1 = 0;
      end else if (!m1_req && $urandom_range(3) == 0) begin
        issue(1, 1'($urandom_range(1)), 16'($urandom),
              $urandom);
      end
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m0_ack) m0_req = 1'b0;
      if (m1_ack) m1_req = 1'b0;
    end
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);
    chk("acked_all", 64'(acked), 64'(issued));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
